// File: rtl/fib_seq_gen_pkg.sv
// Shared encodings and defaults for the Fibonacci term generator.
// FIB_SEQ_GEN_SAT_EN adds the HOLD state that saturate mode parks in.
package fib_seq_gen_pkg;

  localparam int unsigned DEF_WIDTH      = 16;
  localparam int unsigned CNT_W          = 20;
  localparam int unsigned IDX_W          = 16;
  localparam logic [CNT_W-1:0] DEF_DECIMATION = 20'd20;

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'd0,
    MODE_SAT      = 2'd1,
    MODE_RESTART  = 2'd2,
    MODE_WRAP_ALT = 2'd3
  } fib_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1
`ifdef FIB_SEQ_GEN_SAT_EN
    ,
    ST_HOLD = 2'd2
`endif
  } fib_state_e;

endpackage

// File: rtl/fib_tick_div.sv
// Decimation counter: counts 0..DECIMATION-1 while enabled, parks on the last
// count while the consumer is stalled, and flags the emission slot.
module fib_tick_div
  import fib_seq_gen_pkg::*;
#(
  parameter logic [CNT_W-1:0] DECIMATION = DEF_DECIMATION
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_clear,
  input  logic i_hold,
  output logic o_tick
);

  localparam logic [CNT_W-1:0] LAST = DECIMATION - CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == LAST);
  assign o_tick = i_en && w_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (w_last) begin
        // a stalled slot keeps the counter parked so the term is only delayed
        if (!i_hold) r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/fib_seq_gen.sv
// Fibonacci term generator with decimated emission, ready/valid output and
// overflow handling. FIB_SEQ_GEN_SAT_EN enables saturate mode and its HOLD state.
module fib_seq_gen
  import fib_seq_gen_pkg::*;
#(
  parameter int unsigned      WIDTH      = DEF_WIDTH,
  parameter logic [CNT_W-1:0] DECIMATION = DEF_DECIMATION
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             restart,
  input  logic [1:0]       mode,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_index,
  output logic             overflow
);

  localparam logic [WIDTH-1:0] SEED_B = {{(WIDTH-1){1'b0}}, 1'b1};

  fib_state_e       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_data;
  logic [IDX_W-1:0] r_idx, r_out_idx;
  logic             r_valid, r_ovf, r_b_lost;
  logic [WIDTH:0]   w_sum;
  logic             w_carry, w_active, w_slot_free, w_tick, w_emit;
  logic             w_sat_mode, w_rst_mode;
`ifdef FIB_SEQ_GEN_SAT_EN
  logic             r_a_sat, r_b_sat, w_hold_go;
`endif

  assign w_sum       = {1'b0, r_a} + {1'b0, r_b};
  assign w_carry     = w_sum[WIDTH];
  assign w_slot_free = !r_valid || out_ready;
  assign w_emit      = w_tick && w_slot_free && !restart;
  assign w_rst_mode  = (mode == MODE_RESTART);
`ifdef FIB_SEQ_GEN_SAT_EN
  assign w_sat_mode  = (mode == MODE_SAT);
  // the saturated value is being emitted now; nothing may follow it
  assign w_hold_go   = w_emit && r_a_sat;
`else
  assign w_sat_mode  = 1'b0;
`endif

  fib_tick_div #(.DECIMATION(DECIMATION)) u_div (
    .clk    (clk),
    .reset  (reset),
    .i_en   (w_active),
    .i_clear(restart || !w_active),
    .i_hold (!w_slot_free),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (restart) begin
      w_state_nxt = enable ? ST_RUN : ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_RUN: w_state_nxt = enable ? ST_RUN : ST_IDLE;
`ifdef FIB_SEQ_GEN_SAT_EN
        ST_HOLD:         w_state_nxt = ST_HOLD;
`endif
        default:         w_state_nxt = ST_IDLE;
      endcase
`ifdef FIB_SEQ_GEN_SAT_EN
      if (w_hold_go) w_state_nxt = ST_HOLD;
`endif
    end
  end

  // counting already runs in IDLE once enable is seen, so DECIMATION=1 emits on the first edge
  always_comb begin
    w_active = enable;
`ifdef FIB_SEQ_GEN_SAT_EN
    if (r_state == ST_HOLD) w_active = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a       <= '0;
      r_b       <= SEED_B;
      r_idx     <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_out_idx <= '0;
      r_ovf     <= 1'b0;
      r_b_lost  <= 1'b0;
`ifdef FIB_SEQ_GEN_SAT_EN
      r_a_sat   <= 1'b0;
      r_b_sat   <= 1'b0;
`endif
    end else if (restart) begin
      r_a       <= '0;
      r_b       <= SEED_B;
      r_idx     <= '0;
      r_valid   <= 1'b0;
      r_out_idx <= '0;
      r_ovf     <= 1'b0;
      r_b_lost  <= 1'b0;
`ifdef FIB_SEQ_GEN_SAT_EN
      r_a_sat   <= 1'b0;
      r_b_sat   <= 1'b0;
`endif
    end else begin
      if (r_valid && out_ready) r_valid <= 1'b0;
      if (w_emit) begin
        r_valid   <= 1'b1;
        r_data    <= r_a;
        r_out_idx <= r_idx;
        if (r_b_lost) begin
          // b was unrepresentable: the sequence starts over after the last good term
          r_a      <= '0;
          r_b      <= SEED_B;
          r_idx    <= '0;
          r_b_lost <= 1'b0;
`ifdef FIB_SEQ_GEN_SAT_EN
          r_a_sat  <= 1'b0;
          r_b_sat  <= 1'b0;
`endif
        end else begin
          r_a   <= r_b;
          r_b   <= w_sum[WIDTH-1:0];
          r_idx <= r_idx + IDX_W'(1);
          if (w_carry) begin
            r_ovf <= 1'b1;
            if (w_sat_mode)      r_b      <= '1;
            else if (w_rst_mode) r_b_lost <= 1'b1;
          end
`ifdef FIB_SEQ_GEN_SAT_EN
          r_b_sat <= w_carry && w_sat_mode;
          r_a_sat <= r_b_sat;
`endif
        end
      end
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign out_index = r_out_idx;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Directed bench for fib_seq_gen: three WIDTH=8 instances at DECIMATION 4, 2, 1
// share stimulus; accepted terms are logged per instance and compared to hand tables.
module tb_fib_seq_gen;

  typedef struct {
    logic [7:0]  d;
    logic [15:0] i;
    logic        o;
    int          t;
  } rec_t;

  logic        clk, reset, enable, restart, out_ready;
  logic [1:0]  mode;
  logic [7:0]  a_data, b_data, c_data;
  logic [15:0] a_idx, b_idx, c_idx;
  logic        a_valid, b_valid, c_valid, a_ovf, b_ovf, c_ovf;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  rec_t qa[$], qb[$], qc[$];
  logic [7:0] fib8 [0:15] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13,
                              8'd21, 8'd34, 8'd55, 8'd89, 8'd144, 8'd233, 8'd121, 8'd98};

  fib_seq_gen #(.WIDTH(8), .DECIMATION(20'd4)) u_dut_a (
    .clk(clk), .reset(reset), .enable(enable), .restart(restart), .mode(mode),
    .out_ready(out_ready), .out_data(a_data), .out_valid(a_valid),
    .out_index(a_idx), .overflow(a_ovf));

  fib_seq_gen #(.WIDTH(8), .DECIMATION(20'd2)) u_dut_b (
    .clk(clk), .reset(reset), .enable(enable), .restart(restart), .mode(mode),
    .out_ready(out_ready), .out_data(b_data), .out_valid(b_valid),
    .out_index(b_idx), .overflow(b_ovf));

  fib_seq_gen #(.WIDTH(8), .DECIMATION(20'd1)) u_dut_c (
    .clk(clk), .reset(reset), .enable(enable), .restart(restart), .mode(mode),
    .out_ready(out_ready), .out_data(c_data), .out_valid(c_valid),
    .out_index(c_idx), .overflow(c_ovf));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // log terms that will be accepted at the coming edge
  always @(negedge clk) begin
    rec_t r;
    if (a_valid && out_ready) begin
      r.d = a_data; r.i = a_idx; r.o = a_ovf; r.t = cyc; qa.push_back(r);
    end
    if (b_valid && out_ready) begin
      r.d = b_data; r.i = b_idx; r.o = b_ovf; r.t = cyc; qb.push_back(r);
    end
    if (c_valid && out_ready) begin
      r.d = c_data; r.i = c_idx; r.o = c_ovf; r.t = cyc; qc.push_back(r);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    int e0, r0, e1, k, target, n;
    reset = 1'b1; enable = 1'b0; restart = 1'b0; mode = 2'd0; out_ready = 1'b1;
    step(2);
    chk("rst_valid", a_valid, 0);
    chk("rst_data",  a_data,  0);
    chk("rst_index", a_idx,   0);
    chk("rst_ovf",   a_ovf,   0);
    chk("rst_c_valid", c_valid, 0);

    // wrap mode from power-up
    reset = 1'b0; enable = 1'b1; e0 = cyc;
    for (int i = 0; i < 200 && qa.size() < 16; i++) step(1);
    chk("wrap_count", qa.size() >= 16, 1);
    for (int j = 0; j < 16; j++) begin
      chk($sformatf("wrap_d%0d", j), qa[j].d, fib8[j]);
      chk($sformatf("wrap_i%0d", j), qa[j].i, j);
    end
    chk("wrap_ovf11", qa[11].o, 0);
    chk("wrap_ovf12", qa[12].o, 1);
    chk("wrap_ovf15", qa[15].o, 1);
    chk("lat_d4", qa[0].t - e0, 4);
    chk("period_d4", qa[1].t - qa[0].t, 4);
    chk("lat_d2", qb[0].t - e0, 2);
    chk("lat_d1", qc[0].t - e0, 1);
    chk("period_d1", qc[1].t - qc[0].t, 1);

    // restart landing on an emission edge, then restart-on-overflow mode
    k = (cyc - e0) / 4 + 2;
    target = e0 + 4 * k - 1;
    while (cyc < target) step(1);
    restart = 1'b1; mode = 2'd2; qa.delete();
    step(1);
    restart = 1'b0; r0 = cyc;
    @(negedge clk);
    chk("rs_valid", a_valid, 0);
    chk("rs_index", a_idx, 0);
    chk("rs_ovf",   a_ovf, 0);
    chk("rs_noterm", qa.size(), 0);
    for (int i = 0; i < 300 && qa.size() < 17; i++) step(1);
    chk("rmode_count", qa.size() >= 17, 1);
    chk("rs_lat", qa[0].t - r0, 4);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("rs_d%0d", j), qa[j].d, fib8[j]);
      chk($sformatf("rs_i%0d", j), qa[j].i, j);
      chk($sformatf("rs_o%0d", j), qa[j].o, 0);
    end
    chk("rmode_d12", qa[12].d, 144);
    chk("rmode_d13", qa[13].d, 233);
    chk("rmode_d14", qa[14].d, 0);
    chk("rmode_i14", qa[14].i, 0);
    chk("rmode_o14", qa[14].o, 1);
    chk("rmode_d15", qa[15].d, 1);
    chk("rmode_d16", qa[16].d, 1);
    chk("rmode_i16", qa[16].i, 2);

    // saturate mode
    restart = 1'b1; mode = 2'd1; qa.delete();
    step(1);
    restart = 1'b0;
    for (int i = 0; i < 300 && qa.size() < 15; i++) step(1);
    chk("sat_count", qa.size() >= 15, 1);
    step(200);
    chk("sat_d13", qa[13].d, 233);
    chk("sat_i14", qa[14].i, 14);
`ifdef FIB_SEQ_GEN_SAT_EN
    chk("sat_d14", qa[14].d, 255);
    chk("sat_stop", qa.size(), 15);
    chk("sat_valid", a_valid, 0);
`else
    chk("sat_d14", qa[14].d, 121);
    chk("sat_more", qa.size() > 15, 1);
`endif

    // backpressure on the DECIMATION=2 instance
    restart = 1'b1; mode = 2'd0; qb.delete();
    step(1);
    restart = 1'b0;
    for (int i = 0; i < 100 && qb.size() < 4; i++) step(1);
    out_ready = 1'b0;
    n = qb.size();
    step(50);
    chk("bp_valid", b_valid, 1);
    chk("bp_data", b_data, fib8[n]);
    chk("bp_index", b_idx, n);
    out_ready = 1'b1;
    for (int i = 0; i < 200 && qb.size() < 14; i++) step(1);
    chk("bp_count", qb.size() >= 14, 1);
    for (int j = 0; j < 14; j++) begin
      chk($sformatf("bp_d%0d", j), qb[j].d, fib8[j]);
      chk($sformatf("bp_i%0d", j), qb[j].i, j);
    end

    // asynchronous reset mid-cycle, then clean restart of the sequence
    step(3);
    reset = 1'b1;
    #1;
    chk("arst_valid", a_valid, 0);
    chk("arst_index", a_idx, 0);
    chk("arst_ovf",   a_ovf, 0);
    chk("arst_bdata", b_data, 0);
    step(2);
    reset = 1'b0; qa.delete(); e1 = cyc;
    for (int i = 0; i < 50 && qa.size() < 3; i++) step(1);
    chk("post_count", qa.size() >= 3, 1);
    chk("post_lat", qa[0].t - e1, 4);
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("post_d%0d", j), qa[j].d, fib8[j]);
      chk($sformatf("post_i%0d", j), qa[j].i, j);
      chk($sformatf("post_o%0d", j), qa[j].o, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
